spi_adc_rx_mc: RTL and testbench
================================

Name: spi_adc_rx_mc

Overview:
- Parametrised multi-channel SPI slave receiver for the ADC input path: deserialises chip-select-less, MSB-first SPI words clocked by the external master.
- Tags each word with a channel index and runs round-robin over CHANNELS words per frame.
- Sits between the adc_clock/adc_data pins and the sample-processing logic in top, all on the crystal oscillator domain (about 12.09 MHz).
- Adds a configurable word width, channel sequencing, idle-gap frame sync and short-word (bad packet) detection with an error counter.

Parameters:
- WORD_BITS, 16, bits per SPI word (range 4..32).
- CHANNELS, 3, words per frame (range 1..8); channel index wraps at CHANNELS-1.
- TIMEOUT, 64, crystal cycles with no SCK rising edge that end a word/frame (range 8..4095).
- ERRCNT_BITS, 8, width of the saturating error counter.

Ports:
- clock  in  1  system clock (crystal_osc domain).
- reset  in  1  asynchronous, active-high reset.
- spi_clock_in  in  1  external SPI clock; asynchronous to clock; idle low.
- spi_data_in  in  1  external SPI data; the master changes it on the SCK falling edge.
- word_out  out  WORD_BITS  last complete word received.
- word_channel  out  clog2(CHANNELS) (min 1)  channel index of word_out.
- word_valid  out  1  single-cycle pulse when word_out/word_channel update.
- frame_done  out  1  single-cycle pulse, coincident with word_valid for channel CHANNELS-1.
- short_error  out  1  single-cycle pulse when a partial word is discarded.
- error_count  out  ERRCNT_BITS  saturating count of short_error events.
- busy  out  1  high while a word is partially shifted in.

Behaviour:
- Reset:
  - Asynchronous; all outputs go to 0: word_out=0, word_channel=0, word_valid=0, frame_done=0, short_error=0, error_count=0, busy=0.
  - Synchronisers, shift register, bit counter, channel counter and idle counter are cleared.
  - The idle counter is also cleared.
- Input synchronisation:
  - spi_clock_in and spi_data_in each pass through a 2-flop synchroniser.
  - A third SCK flop provides rising-edge detect (sync2 & ~sync3).
- Shifting:
  - On a detected rising edge, the data bit is shifted into the LSB (MSB-first order) and bit_cnt increments.
  - busy=1 whenever bit_cnt != 0.
- Word completion:
  - When the edge that brings bit_cnt to WORD_BITS is detected, on the next clock:
    - word_out = the shifted word.
    - word_channel = the channel counter.
    - word_valid = 1 for exactly one cycle.
  - bit_cnt returns to 0 and the channel counter increments, wrapping from CHANNELS-1 to 0.
  - frame_done pulses with word_valid when the completed channel is CHANNELS-1.
- Latency: word_valid rises 4 clock edges after the first clock edge that samples the final SCK rising edge high (2 sync + edge detect + output register).
- Idle counter:
  - Cleared on every detected SCK rising edge.
  - Otherwise increments and saturates at TIMEOUT.
  - When it reaches TIMEOUT (a one-shot, on the reaching cycle only):
    - If bit_cnt != 0: discard the partial word, bit_cnt=0, short_error pulses one cycle, error_count increments (saturates at all-ones). word_out is unchanged.
    - The channel counter resets to 0 in all cases; an idle gap always starts a new frame.
- Simultaneous events:
  - An SCK edge on the same cycle the counter would reach TIMEOUT takes priority: the counter clears and no timeout occurs.
  - A word completion and a timeout cannot coincide, because the counter cleared on that edge.
- Partial frames: if fewer than CHANNELS words arrive before an idle gap, no frame_done is issued and the next word is channel 0. This is not counted as an error.
- Reset mid-word: the partial word is lost, no short_error is issued and counters restart.
- Rate limit: the SCK high and low phases must each be at least 3 clock periods. Faster SCK gives undefined results and is not detected.

Test Plan:
- Reset release, no SCK activity for 200 cycles -> all outputs stay 0, no short_error.
- Send three 16-bit words 0x96AA, 0x5533, 0x1655 with 375 ns SCK half-periods, 1 µs gaps -> word_valid x3 with channels 0, 1, 2; word_out values in that order; frame_done only with 0x1655; word_valid 4 cycles after final SCK sample.
- Send only 15 bits of 0x96AA, then idle for more than TIMEOUT -> short_error pulses once, error_count=1, word_out unchanged. A following full 0x5533 reports channel 0.
- Send 0x96AA, 0x5533, then idle for more than TIMEOUT, then 0x1655 -> channels 0, 1, 0; no frame_done; error_count unchanged.
- Assert reset after 8 bits of 0xAACC -> outputs 0 immediately (asynchronous). After release, a full 0xAACC -> word_out=0xAACC, channel 0, no error.
- WORD_BITS=12, CHANNELS=1, ERRCNT_BITS=2: send 0xABC -> word_out=0xABC, frame_done on every word. Five short words -> error_count saturates at 3.

Source files
------------

// File: rtl/spi_adc_rx_mc.sv
// Multi-channel SPI slave receiver for the ADC input path.
// Deserialises MSB-first words, tags channels, detects idle gaps and short words.
module spi_adc_rx_mc #(
    parameter int WORD_BITS   = 16,
    parameter int CHANNELS    = 3,
    parameter int TIMEOUT     = 64,
    parameter int ERRCNT_BITS = 8,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   spi_clock_in,
    input  logic                   spi_data_in,
    output logic [WORD_BITS-1:0]   word_out,
    output logic [CW-1:0]          word_channel,
    output logic                   word_valid,
    output logic                   frame_done,
    output logic                   short_error,
    output logic [ERRCNT_BITS-1:0] error_count,
    output logic                   busy
);

    localparam int BW = $clog2(WORD_BITS + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic                 sck_s1, sck_s2, sck_s3;
    logic                 dat_s1, dat_s2;
    logic                 rise_r, dat_r;
    logic                 word_rdy;
    logic [WORD_BITS-1:0] shift_reg;
    logic [BW-1:0]        bit_cnt;
    logic [CW-1:0]        chan_cnt;
    logic [IW-1:0]        idle_cnt;

    assign busy = (bit_cnt != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_s1       <= 1'b0;
            sck_s2       <= 1'b0;
            sck_s3       <= 1'b0;
            dat_s1       <= 1'b0;
            dat_s2       <= 1'b0;
            rise_r       <= 1'b0;
            dat_r        <= 1'b0;
            word_rdy     <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            chan_cnt     <= '0;
            idle_cnt     <= '0;
            word_out     <= '0;
            word_channel <= '0;
            word_valid   <= 1'b0;
            frame_done   <= 1'b0;
            short_error  <= 1'b0;
            error_count  <= '0;
        end else begin
            sck_s1      <= spi_clock_in;
            sck_s2      <= sck_s1;
            sck_s3      <= sck_s2;
            dat_s1      <= spi_data_in;
            dat_s2      <= dat_s1;
            // Registered edge detect keeps data and strobe aligned
            rise_r      <= sck_s2 & ~sck_s3;
            dat_r       <= dat_s2;
            word_valid  <= 1'b0;
            frame_done  <= 1'b0;
            short_error <= 1'b0;
            word_rdy    <= 1'b0;

            if (rise_r) begin
                shift_reg <= {shift_reg[WORD_BITS-2:0], dat_r};
                bit_cnt   <= bit_cnt + 1'b1;
                idle_cnt  <= '0;
                word_rdy  <= (bit_cnt == BW'(WORD_BITS - 1));
            end else begin
                if (idle_cnt != IW'(TIMEOUT))
                    idle_cnt <= idle_cnt + 1'b1;
                // One-shot on the cycle the idle gap reaches TIMEOUT
                if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    chan_cnt <= '0;
                    if (bit_cnt != '0) begin
                        bit_cnt     <= '0;
                        short_error <= 1'b1;
                        if (error_count != '1)
                            error_count <= error_count + 1'b1;
                    end
                end
            end

            if (word_rdy) begin
                word_out     <= shift_reg;
                word_channel <= chan_cnt;
                word_valid   <= 1'b1;
                frame_done   <= (chan_cnt == CW'(CHANNELS - 1));
                bit_cnt      <= '0;
                if (chan_cnt == CW'(CHANNELS - 1))
                    chan_cnt <= '0;
                else
                    chan_cnt <= chan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_rx_mc.sv
// Directed bench for spi_adc_rx_mc: default build plus a 12-bit single-channel build.
module tb_spi_adc_rx_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck1 = 1'b0, dat1 = 1'b0;
    logic sck2 = 1'b0, dat2 = 1'b0;

    logic [15:0] wo1;
    logic [1:0]  ch1;
    logic        wv1, fd1, se1, busy1;
    logic [7:0]  ec1;

    logic [11:0] wo2;
    logic [0:0]  ch2;
    logic        wv2, fd2, se2, busy2;
    logic [1:0]  ec2;

    int total = 0;
    int bad = 0;

    logic [31:0] wq[$];
    int          cq[$];
    bit          fq[$];
    int          se_n1 = 0, se_n2 = 0, fd_orphan = 0;

    always #40 clk = ~clk;

    spi_adc_rx_mc u_dut1 (
        .clock(clk), .reset(rst),
        .spi_clock_in(sck1), .spi_data_in(dat1),
        .word_out(wo1), .word_channel(ch1),
        .word_valid(wv1), .frame_done(fd1),
        .short_error(se1), .error_count(ec1),
        .busy(busy1)
    );

    spi_adc_rx_mc #(.WORD_BITS(12), .CHANNELS(1), .ERRCNT_BITS(2)) u_dut2 (
        .clock(clk), .reset(rst),
        .spi_clock_in(sck2), .spi_data_in(dat2),
        .word_out(wo2), .word_channel(ch2),
        .word_valid(wv2), .frame_done(fd2),
        .short_error(se2), .error_count(ec2),
        .busy(busy2)
    );

    always @(negedge clk) begin
        if (wv1) begin
            wq.push_back(32'(wo1));
            cq.push_back(int'(ch1));
            fq.push_back(fd1);
        end
        if (wv2) begin
            wq.push_back(32'(wo2));
            cq.push_back(int'(ch2));
            fq.push_back(fd2);
        end
        if ((fd1 && !wv1) || (fd2 && !wv2)) fd_orphan++;
        if (se1) se_n1++;
        if (se2) se_n2++;
    end

    task automatic clear_q();
        wq.delete();
        cq.delete();
        fq.delete();
    endtask

    task automatic half();
        #375;
        @(negedge clk);
    endtask

    task automatic drv(input bit sel, input logic s, input logic d);
        if (sel) begin sck2 = s; dat2 = d; end
        else begin sck1 = s; dat1 = d; end
    endtask

    // Sends the top nbits of a wb-bit word; optionally checks output latency
    task automatic send(input bit sel, input logic [31:0] w, input int wb,
                        input int nbits, input bit lat);
        logic b;
        logic v;
        for (int i = 0; i < nbits; i++) begin
            b = w[wb-1-i];
            drv(sel, 1'b0, b);
            half();
            drv(sel, 1'b1, b);
            if (lat && i == nbits - 1) begin
                for (int e = 0; e < 4; e++) begin
                    @(posedge clk); #1;
                    v = sel ? wv2 : wv1;
                    total++;
                    if (v !== 1'b0) begin
                        bad++;
                        $display("FAIL latency_early edge=%0d got=%b exp=0", e, v);
                    end
                end
                @(posedge clk); #1;
                v = sel ? wv2 : wv1;
                total++;
                if (v !== 1'b1) begin
                    bad++;
                    $display("FAIL latency_edge4 got=%b exp=1", v);
                end
            end else begin
                half();
            end
            drv(sel, 1'b0, b);
        end
    endtask

    task automatic test_reset();
        bit seen = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (wo1 !== 0 || ch1 !== 0 || wv1 !== 0 || fd1 !== 0 ||
                se1 !== 0 || ec1 !== 0 || busy1 !== 0) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_outputs got=%b exp=0", seen);
        end
        total++;
        if (se_n1 !== 0) begin
            bad++;
            $display("FAIL reset_short_err got=%0d exp=0", se_n1);
        end
        total++;
        if (wq.size() !== 0) begin
            bad++;
            $display("FAIL reset_words got=%0d exp=0", wq.size());
        end
    endtask

    task automatic test_frame();
        logic [31:0] ew[3] = '{32'h96AA, 32'h5533, 32'h1655};
        bit          ef[3] = '{1'b0, 1'b0, 1'b1};
        clear_q();
        send(0, ew[0], 16, 16, 1);
        #1000;
        send(0, ew[1], 16, 16, 1);
        #1000;
        send(0, ew[2], 16, 16, 1);
        repeat (10) @(negedge clk);
        total++;
        if (wq.size() !== 3) begin
            bad++;
            $display("FAIL frame_count got=%0d exp=3", wq.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (wq.size() > i) begin
                total += 3;
                if (wq[i] !== ew[i]) begin
                    bad++;
                    $display("FAIL frame_word%0d got=%h exp=%h", i, wq[i], ew[i]);
                end
                if (cq[i] !== i) begin
                    bad++;
                    $display("FAIL frame_chan%0d got=%0d exp=%0d", i, cq[i], i);
                end
                if (fq[i] !== ef[i]) begin
                    bad++;
                    $display("FAIL frame_done%0d got=%b exp=%b", i, fq[i], ef[i]);
                end
            end
        end
        total++;
        if (fd_orphan !== 0) begin
            bad++;
            $display("FAIL frame_orphan got=%0d exp=0", fd_orphan);
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic test_short();
        int base = se_n1;
        clear_q();
        send(0, 32'h96AA, 16, 15, 0);
        repeat (100) @(negedge clk);
        total += 4;
        if (se_n1 - base !== 1) begin
            bad++;
            $display("FAIL short_pulses got=%0d exp=1", se_n1 - base);
        end
        if (ec1 !== 8'd1) begin
            bad++;
            $display("FAIL short_errcnt got=%0d exp=1", ec1);
        end
        if (wo1 !== 16'h1655) begin
            bad++;
            $display("FAIL short_word_kept got=%h exp=1655", wo1);
        end
        if (wq.size() !== 0) begin
            bad++;
            $display("FAIL short_no_valid got=%0d exp=0", wq.size());
        end
        send(0, 32'h5533, 16, 16, 1);
        repeat (10) @(negedge clk);
        total++;
        if (wq.size() !== 1 || wq[0] !== 32'h5533 || cq[0] !== 0) begin
            bad++;
            $display("FAIL short_next_word got_n=%0d exp_n=1 exp=5533 ch0",
                     wq.size());
        end
    endtask

    task automatic test_partial();
        logic [31:0] ew[3] = '{32'h96AA, 32'h5533, 32'h1655};
        int          ec[3] = '{0, 1, 0};
        repeat (100) @(negedge clk);
        clear_q();
        send(0, ew[0], 16, 16, 0);
        #1000;
        send(0, ew[1], 16, 16, 0);
        repeat (100) @(negedge clk);
        send(0, ew[2], 16, 16, 0);
        repeat (10) @(negedge clk);
        total++;
        if (wq.size() !== 3) begin
            bad++;
            $display("FAIL partial_count got=%0d exp=3", wq.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (wq.size() > i) begin
                total += 3;
                if (wq[i] !== ew[i]) begin
                    bad++;
                    $display("FAIL partial_word%0d got=%h exp=%h", i, wq[i], ew[i]);
                end
                if (cq[i] !== ec[i]) begin
                    bad++;
                    $display("FAIL partial_chan%0d got=%0d exp=%0d", i, cq[i], ec[i]);
                end
                if (fq[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL partial_fd%0d got=%b exp=0", i, fq[i]);
                end
            end
        end
        total++;
        if (ec1 !== 8'd1) begin
            bad++;
            $display("FAIL partial_errcnt got=%0d exp=1", ec1);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        send(0, 32'hAACC, 16, 8, 0);
        @(negedge clk);
        total++;
        if (busy1 !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy got=%b exp=1", busy1);
        end
        rst = 1'b1;
        #5;
        total++;
        if (wo1 !== 0 || ch1 !== 0 || ec1 !== 0 || busy1 !== 0 || wv1 !== 0) begin
            bad++;
            $display("FAIL mid_async_clear got=%h/%0d/%0d/%b exp=0/0/0/0",
                     wo1, ch1, ec1, busy1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        clear_q();
        base = se_n1;
        send(0, 32'hAACC, 16, 16, 1);
        repeat (10) @(negedge clk);
        total += 2;
        if (wq.size() !== 1 || wq[0] !== 32'hAACC || cq[0] !== 0) begin
            bad++;
            $display("FAIL mid_word got_n=%0d exp_n=1 exp=aacc ch0", wq.size());
        end
        if (se_n1 !== base || ec1 !== 0) begin
            bad++;
            $display("FAIL mid_no_error got=%0d/%0d exp=0/0", se_n1 - base, ec1);
        end
    endtask

    task automatic test_small();
        int base;
        clear_q();
        send(1, 32'hABC, 12, 12, 1);
        #1000;
        send(1, 32'h123, 12, 12, 1);
        repeat (10) @(negedge clk);
        total++;
        if (wq.size() !== 2) begin
            bad++;
            $display("FAIL small_count got=%0d exp=2", wq.size());
        end
        if (wq.size() == 2) begin
            total += 3;
            if (wq[0] !== 32'hABC || wq[1] !== 32'h123) begin
                bad++;
                $display("FAIL small_words got=%h,%h exp=abc,123", wq[0], wq[1]);
            end
            if (cq[0] !== 0 || cq[1] !== 0) begin
                bad++;
                $display("FAIL small_chan got=%0d,%0d exp=0,0", cq[0], cq[1]);
            end
            if (fq[0] !== 1'b1 || fq[1] !== 1'b1) begin
                bad++;
                $display("FAIL small_frame got=%b,%b exp=1,1", fq[0], fq[1]);
            end
        end
        base = se_n2;
        for (int k = 0; k < 5; k++) begin
            send(1, 32'hFFF, 12, 5, 0);
            repeat (100) @(negedge clk);
        end
        total += 3;
        if (ec2 !== 2'd3) begin
            bad++;
            $display("FAIL small_errsat got=%0d exp=3", ec2);
        end
        if (se_n2 - base !== 5) begin
            bad++;
            $display("FAIL small_pulses got=%0d exp=5", se_n2 - base);
        end
        if (wo2 !== 12'h123) begin
            bad++;
            $display("FAIL small_word_kept got=%h exp=123", wo2);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_short();
        test_partial();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
